gate_truth_checker: RTL and testbench
=====================================

// Module: gate_truth_checker
// PURPOSE
//   Self-checking stimulus/response stage for a 2-input combinational gate (default target: nor_gate).
//   On start, drives a/b through all four input patterns in order 00,01,10,11 and waits SETTLE_CYCLES per pattern.
//   Samples the gate output y and compares it against the TRUTH table.
//   Reports mismatch count, a per-pattern fail vector and a pass flag.
//   Sits directly upstream of the gate (feeds a/b) and downstream of it (consumes y); replaces hand-written stimulus.
// PARAMETERS
//   SETTLE_CYCLES  2        cycles each pattern is held before y is sampled; legal range >=1
//   PASSES         1        number of full 4-pattern sweeps per start; legal range >=1
//   TRUTH          4'b0001  expected y, indexed by {a,b}; bit0 = pattern 00 (NOR)
//   ERR_W          4        width of err_count
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      begin a run; sampled only in IDLE
//   y          in   1      output of gate under check
//   a          out  1      gate input a (MSB of pattern index)
//   b          out  1      gate input b (LSB of pattern index)
//   busy       out  1      high while a sweep is in progress
//   done       out  1      one-cycle pulse at end of run
//   pass       out  1      1 = last run had zero mismatches; held until next start
//   err_count  out  ERR_W  mismatches in last run; saturates at 2^ERR_W-1
//   fail_vec   out  4      sticky per-pattern mismatch flags for last run; bit i = pattern i
// BEHAVIOUR
//   Reset: all outputs 0 and state IDLE. Assertion mid-run aborts immediately; no done pulse is issued.
//   FSM states: IDLE, SETTLE, DONE. Outputs are registered (Moore).
//   IDLE:   start=1 at edge E0 clears err_count, fail_vec and pass.
//           Then sets idx=0, {a,b}=00, cnt=SETTLE_CYCLES-1, pass_cnt=0, busy=1, and moves to SETTLE.
//   SETTLE: cnt>0 -> decrement cnt.
//           cnt==0 -> compare y with TRUTH[idx]. On mismatch: set fail_vec[idx] and increment err_count (saturating).
//           Then, if idx==3 && pass_cnt==PASSES-1 -> DONE.
//           Otherwise idx <= idx+1 (3 wraps to 0, pass_cnt++), {a,b} <= new idx, cnt reloads, and the FSM stays in SETTLE.
//   DONE:   done=1 and busy=0 for exactly one cycle; pass=(err_count==0); a/b hold last pattern; then IDLE.
//   Timing: each pattern is held exactly SETTLE_CYCLES cycles.
//           The final compare occurs at edge E0+4*PASSES*SETTLE_CYCLES.
//           done is high during the following cycle.
//   start is ignored while busy or in DONE. A new run can start in the first IDLE cycle after DONE.
//   y is sampled only on compare edges; y values between compare edges are ignored.
// CONFIGURATION
//   GATE_CHK_STOP_ON_ERR_EN defined: the first mismatch goes straight to DONE from the compare edge.
//     In that case err_count=1, only that fail_vec bit is set, and pass=0.
//   GATE_CHK_STOP_ON_ERR_EN undefined: every pattern of every pass is checked regardless of errors.
// STRUCTURE
//   gate_chk_pkg: state encoding constants, NUM_PATTERNS=4, NOR/AND/OR/XOR truth constants.
//   Sub-module gate_chk_settle_timer: loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES+1).
//   Top module holds the FSM, the idx/pass counters and the check/score registers.
// TESTING (SETTLE_CYCLES=2 unless stated; E0 = edge that samples start)
//   1. nor_gate DUT, PASSES=1, pulse start.
//      -> a/b show 00,01,10,11 for 2 cycles each.
//      -> done high after edge E0+8, err_count=0, fail_vec=0000, pass=1, busy low.
//   2. AND gate in place of NOR.
//      -> err_count=2, fail_vec=4'b1001, pass=0, done after E0+8.
//   3. Same AND DUT with GATE_CHK_STOP_ON_ERR_EN defined.
//      -> done after E0+2, err_count=1, fail_vec=4'b0001, a/b=00.
//   4. y tied to 1, PASSES=3, ERR_W=2.
//      -> 9 raw mismatches, so err_count saturates at 3.
//      -> fail_vec=4'b1110, done after E0+24.
//   5. nor_gate DUT, assert rst at E0+3 for one cycle.
//      -> all outputs 0, no done pulse.
//      -> next start yields a clean pass as in test 1.
//   6. Pulse start again at E0+4 mid-run.
//      -> ignored: sequence and done timing identical to test 1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding,
// pattern count and the truth tables of the common 2-input gates.
package gate_chk_pkg;

  localparam int NUM_PATTERNS = 4;

  // Expected y indexed by {a,b}; bit0 is pattern 00
  localparam logic [NUM_PATTERNS-1:0] TRUTH_NOR = 4'b0001;
  localparam logic [NUM_PATTERNS-1:0] TRUTH_AND = 4'b1000;
  localparam logic [NUM_PATTERNS-1:0] TRUTH_OR  = 4'b1110;
  localparam logic [NUM_PATTERNS-1:0] TRUTH_XOR = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Reference output of the gate for one input pattern
  function automatic logic truth_bit(input logic [NUM_PATTERNS-1:0] truth,
                                     input logic [1:0] idx);
    return truth[idx];
  endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Connection bundle between the checker, the gate under check and
// whoever launches runs and reads the results.
// master: the checker itself; slave: the gate plus the controlling side.
interface gate_truth_checker_if
  import gate_chk_pkg::*;
#(
  parameter int ERR_W = 4
) ();

  logic                    start;
  logic                    y;
  logic                    a;
  logic                    b;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [ERR_W-1:0]        err_count;
  logic [NUM_PATTERNS-1:0] fail_vec;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/gate_chk_settle_timer.sv
// Loadable down-counter that times how long each input pattern is held.
// Loading puts SETTLE_CYCLES-1 in the counter; zero marks the compare cycle.
module gate_chk_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Reload wins over counting; the counter parks at zero until reloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through patterns 00,01,10,11, holds each for
// SETTLE_CYCLES cycles, compares y against TRUTH and scores the run.
// Optional build macro GATE_CHK_STOP_ON_ERR_EN: end the run on the
// first mismatch instead of finishing every pattern of every pass.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int                      SETTLE_CYCLES = 2,
  parameter int                      PASSES        = 1,
  parameter logic [NUM_PATTERNS-1:0] TRUTH         = TRUTH_NOR,
  parameter int                      ERR_W         = 4
) (
  input logic clk,
  input logic rst,
  gate_truth_checker_if.master chk
);

  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PC_W-1:0]  LAST_PASS = PC_W'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t                  state, state_n;
  logic [1:0]              idx, idx_n;
  logic [PC_W-1:0]         pass_cnt, pass_cnt_n;
  logic                    busy, busy_n;
  logic                    done, done_n;
  logic                    pass, pass_n;
  logic [ERR_W-1:0]        err_count, err_n;
  logic [NUM_PATTERNS-1:0] fail_vec, fail_n;
  logic                    tmr_load;
  logic                    tmr_en;
  logic                    tmr_zero;
  logic                    mismatch;
  logic                    last_cmp;
  logic                    goto_done;

  gate_chk_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .en  (tmr_en),
    .zero(tmr_zero)
  );

  // Next state plus next value of every scored output, so all outputs leave registered
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    pass_cnt_n = pass_cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    err_n      = err_count;
    fail_n     = fail_vec;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    mismatch   = 1'b0;
    last_cmp   = 1'b0;
    goto_done  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (chk.start) begin
          err_n      = '0;
          fail_n     = '0;
          pass_n     = 1'b0;
          idx_n      = 2'd0;
          pass_cnt_n = '0;
          busy_n     = 1'b1;
          tmr_load   = 1'b1;
          state_n    = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          mismatch = (chk.y != truth_bit(TRUTH, idx));
          if (mismatch) begin
            fail_n[idx] = 1'b1;
            if (err_count != ERR_MAX) begin
              err_n = err_count + ERR_W'(1);
            end
          end
          last_cmp = (idx == 2'd3) && (pass_cnt == LAST_PASS);
`ifdef GATE_CHK_STOP_ON_ERR_EN
          goto_done = last_cmp || mismatch;
`else
          goto_done = last_cmp;
`endif
          if (goto_done) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
            state_n = ST_DONE;
          end else begin
            idx_n    = idx + 2'd1;
            tmr_load = 1'b1;
            if (idx == 2'd3) begin
              pass_cnt_n = pass_cnt + PC_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      pass_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pass_cnt  <= pass_cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_vec  <= fail_n;
    end
  end

  assign chk.a         = idx[1];
  assign chk.b         = idx[0];
  assign chk.busy      = busy;
  assign chk.done      = done;
  assign chk.pass      = pass;
  assign chk.err_count = err_count;
  assign chk.fail_vec  = fail_vec;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two checker instances, one on a
// switchable NOR/AND gate model and one (PASSES=3, ERR_W=2) on y tied high.
// Runs are launched with expected results pushed to scoreboards; monitors
// pop and compare whenever a checker is busy or pulses done.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int SC = 2;

  typedef struct {
    int         done_cyc;
    logic [3:0] err;
    logic [3:0] fail;
    logic       pass;
    logic [1:0] ab;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   gate_mode;
  int   n_cmp;
  int   n_miss;

  exp_t       sb_a[$];
  exp_t       sb_b[$];
  logic [1:0] ab_a[$];
  logic [1:0] ab_b[$];

  gate_truth_checker_if #(.ERR_W(4)) if_a ();
  gate_truth_checker_if #(.ERR_W(2)) if_b ();

  gate_truth_checker #(
    .SETTLE_CYCLES(SC),
    .PASSES       (1),
    .TRUTH        (TRUTH_NOR),
    .ERR_W        (4)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .chk(if_a)
  );

  gate_truth_checker #(
    .SETTLE_CYCLES(SC),
    .PASSES       (3),
    .TRUTH        (TRUTH_NOR),
    .ERR_W        (2)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .chk(if_b)
  );

  // Gate under check for dut_a: 0 = correct NOR, 1 = wrong AND
  assign if_a.y = (gate_mode == 0) ? ~(if_a.a | if_a.b) : (if_a.a & if_a.b);
  // dut_b sees a stuck-at-1 gate output
  assign if_b.y = 1'b1;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to time the done pulse
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkDone(input string tag, input exp_t e, input int c,
                           input logic [3:0] err, input logic [3:0] fail,
                           input logic pass, input logic busy, input logic [1:0] ab);
    checkOutput({tag, "_done_cycle"}, c, e.done_cyc);
    checkOutput({tag, "_err_count"}, int'(err), int'(e.err));
    checkOutput({tag, "_fail_vec"}, int'(fail), int'(e.fail));
    checkOutput({tag, "_pass"}, int'(pass), int'(e.pass));
    checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
    checkOutput({tag, "_ab_at_done"}, int'(ab), int'(e.ab));
  endtask

  // Monitor for dut_a: pattern sequence while busy, scored result on done
  always @(negedge clk) begin
    if (!rst) begin
      if (if_a.busy) begin
        if (ab_a.size() == 0) checkOutput("a_busy_unexpected", int'(if_a.busy), 0);
        else checkOutput("a_ab_seq", int'({if_a.a, if_a.b}), int'(ab_a.pop_front()));
      end
      if (if_a.done) begin
        if (sb_a.size() == 0) checkOutput("a_done_unexpected", int'(if_a.done), 0);
        else checkDone("a", sb_a.pop_front(), cyc, if_a.err_count, if_a.fail_vec,
                       if_a.pass, if_a.busy, {if_a.a, if_a.b});
      end
    end
  end

  // Monitor for dut_b, same scheme
  always @(negedge clk) begin
    if (!rst) begin
      if (if_b.busy) begin
        if (ab_b.size() == 0) checkOutput("b_busy_unexpected", int'(if_b.busy), 0);
        else checkOutput("b_ab_seq", int'({if_b.a, if_b.b}), int'(ab_b.pop_front()));
      end
      if (if_b.done) begin
        if (sb_b.size() == 0) checkOutput("b_done_unexpected", int'(if_b.done), 0);
        else checkDone("b", sb_b.pop_front(), cyc, {2'b00, if_b.err_count}, if_b.fail_vec,
                       if_b.pass, if_b.busy, {if_b.a, if_b.b});
      end
    end
  end

  // Pulse start for one edge and queue the expected sequence and result
  task automatic applyStimulus(input int which, input exp_t e, input int lat, input int n_pat);
    @(negedge clk);
    e.done_cyc = cyc + 1 + lat;
    for (int k = 0; k < n_pat; k++) begin
      for (int r = 0; r < SC; r++) begin
        if (which == 0) ab_a.push_back(2'(k % 4));
        else ab_b.push_back(2'(k % 4));
      end
    end
    if (which == 0) begin
      sb_a.push_back(e);
      if_a.start = 1'b1;
    end else begin
      sb_b.push_back(e);
      if_b.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  // Wait for a scoreboard to drain, scoring an expired budget as a failure
  task automatic waitIdle(input int which, input int budget);
    int left;
    left = budget;
    while (((which == 0) ? sb_a.size() : sb_b.size()) != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    checkOutput((which == 0) ? "a_timeout_pending" : "b_timeout_pending",
                (which == 0) ? sb_a.size() : sb_b.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a"}, int'(if_a.a), 0);
    checkOutput({tag, "_b"}, int'(if_a.b), 0);
    checkOutput({tag, "_busy"}, int'(if_a.busy), 0);
    checkOutput({tag, "_done"}, int'(if_a.done), 0);
    checkOutput({tag, "_pass"}, int'(if_a.pass), 0);
    checkOutput({tag, "_err_count"}, int'(if_a.err_count), 0);
    checkOutput({tag, "_fail_vec"}, int'(if_a.fail_vec), 0);
  endtask

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with hand-computed results
  initial begin
    exp_t e_nor, e_and, e_y1;
    e_nor = '{done_cyc: 0, err: 4'd0, fail: 4'b0000, pass: 1'b1, ab: 2'b11};
`ifdef GATE_CHK_STOP_ON_ERR_EN
    e_and = '{done_cyc: 0, err: 4'd1, fail: 4'b0001, pass: 1'b0, ab: 2'b00};
    e_y1  = '{done_cyc: 0, err: 4'd1, fail: 4'b0010, pass: 1'b0, ab: 2'b01};
`else
    e_and = '{done_cyc: 0, err: 4'd2, fail: 4'b1001, pass: 1'b0, ab: 2'b11};
    e_y1  = '{done_cyc: 0, err: 4'd3, fail: 4'b1110, pass: 1'b0, ab: 2'b11};
`endif
    n_cmp     = 0;
    n_miss    = 0;
    cyc       = 0;
    gate_mode = 0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_b_busy", int'(if_b.busy), 0);
    checkOutput("reset_b_err_count", int'(if_b.err_count), 0);

    $display("[TB] scenario: NOR gate, single pass");
    applyStimulus(0, e_nor, 4 * SC, 4);
    waitIdle(0, 40);

    $display("[TB] scenario: AND gate in place of NOR");
    gate_mode = 1;
`ifdef GATE_CHK_STOP_ON_ERR_EN
    applyStimulus(0, e_and, SC, 1);
`else
    applyStimulus(0, e_and, 4 * SC, 4);
`endif
    waitIdle(0, 40);
    gate_mode = 0;

    $display("[TB] scenario: y stuck high, three passes, 2-bit error count");
`ifdef GATE_CHK_STOP_ON_ERR_EN
    applyStimulus(1, e_y1, 2 * SC, 2);
`else
    applyStimulus(1, e_y1, 12 * SC, 12);
`endif
    waitIdle(1, 80);

    $display("[TB] scenario: reset in the middle of a run");
    applyStimulus(0, e_nor, 4 * SC, 4);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_a.delete();
    ab_a.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    repeat (12) @(negedge clk);
    applyStimulus(0, e_nor, 4 * SC, 4);
    waitIdle(0, 40);

    $display("[TB] scenario: start pulsed again mid-run");
    applyStimulus(0, e_nor, 4 * SC, 4);
    repeat (3) @(posedge clk);
    #1;
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    waitIdle(0, 40);
    repeat (6) @(negedge clk);
    checkOutput("leftover_ab_a", ab_a.size(), 0);
    checkOutput("leftover_ab_b", ab_b.size(), 0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
